// File: rtl/risac_key_pio.sv
`default_nettype none
// ============================================================================
// Module   : risac_key_pio
// Purpose  : Debounced switch/key parallel input port with an Avalon-MM slave.
//            Raw pins are synchronized, sampled on a slow tick, and accepted
//            only after three equal consecutive samples. Rising edges of the
//            debounced value are latched in a W1C edge-capture register that,
//            gated by an interrupt mask, drives a level interrupt.
// Ports    : clock50       - sole clock, rising edge
//            reset         - asynchronous active-high reset
//            sw_in         - raw asynchronous pins [WIDTH-1:0]
//            avs_address   - word address (0 db, 1 sync, 2 irqmask, 3 edgecap)
//            avs_read      - read strobe, data returned on the next edge
//            avs_write     - write strobe
//            avs_writedata - write data
//            avs_readdata  - registered read data, zero-extended
//            irq           - level interrupt, OR of masked edge-capture bits
// Revision : 1.0 - initial release
// ============================================================================
module risac_key_pio #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clock50,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    localparam int                c_CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_TICK_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_ADDR_DB   = 2'd0;
    localparam logic [1:0] c_ADDR_SYNC = 2'd1;
    localparam logic [1:0] c_ADDR_MASK = 2'd2;
    localparam logic [1:0] c_ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0]   r_meta;
    logic [WIDTH-1:0]   r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_h0;
    logic [WIDTH-1:0]   r_h1;
    logic [WIDTH-1:0]   r_db;
    logic [WIDTH-1:0]   r_edgecap;
    logic [WIDTH-1:0]   r_irqmask;
    logic [31:0]        r_readdata;

    logic               w_tick;
    logic [WIDTH-1:0]   w_stable;
    logic [WIDTH-1:0]   w_db_next;
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_clr;
    logic               w_wr_mask;
    logic               w_wr_edge;
    logic [31:0]        w_rd_mux;

    // Two-flop synchronizer; the only logic that touches the raw pins.
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= sw_in;
            r_sync <= r_meta;
        end
    end

    // Free-running sample-tick divider.
    assign w_tick = (r_cnt == c_TICK_MAX);

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A bit is stable when the current synchronized value matches the two
    // previous tick samples (all pre-update values).
    assign w_stable  = ~(r_sync ^ r_h0) & ~(r_h0 ^ r_h1);
    assign w_db_next = w_tick ? ((r_db & ~w_stable) | (r_sync & w_stable)) : r_db;
    assign w_rise    = w_db_next & ~r_db;

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            r_h0 <= '0;
            r_h1 <= '0;
            r_db <= '0;
        end else begin
            if (w_tick) begin
                r_h1 <= r_h0;
                r_h0 <= r_sync;
            end
            r_db <= w_db_next;
        end
    end

    // Register writes. Addresses 0 and 1 are read-only and decode to nothing.
    assign w_wr_mask = avs_write && (avs_address == c_ADDR_MASK);
    assign w_wr_edge = avs_write && (avs_address == c_ADDR_EDGE);
    assign w_clr     = w_wr_edge ? avs_writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            r_irqmask <= '0;
        end else if (w_wr_mask) begin
            r_irqmask <= avs_writedata[WIDTH-1:0];
        end
    end

    // Set is OR-ed after the clear so a rising edge wins over a W1C.
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_rise;
        end
    end

    // Read mux uses current flop values, so a read colliding with a write
    // returns the pre-write contents.
    always_comb begin
        w_rd_mux = '0;
        case (avs_address)
            c_ADDR_DB:   w_rd_mux[WIDTH-1:0] = r_db;
            c_ADDR_SYNC: w_rd_mux[WIDTH-1:0] = r_sync;
            c_ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
            c_ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edgecap;
            default:     w_rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (avs_read) begin
            r_readdata <= w_rd_mux;
        end
    end

    assign avs_readdata = r_readdata;
    assign irq          = |(r_edgecap & r_irqmask);

    // Write-data bits above WIDTH carry no function.
    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic w_unused;
            assign w_unused = &{1'b0, avs_writedata[31:WIDTH]};
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_risac_key_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_risac_key_pio
// Purpose  : Self-checking bench for risac_key_pio (WIDTH=10, DEBOUNCE=4).
//            A behavioural model tracks the pins through a two-cycle delay,
//            keeps the last tick samples, and predicts the register file,
//            read data and interrupt every cycle. Table vectors and directed
//            sequences add hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_risac_key_pio;

    localparam int W = 10;
    localparam int D = 4;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic [W-1:0]  sw    = '0;
    logic [1:0]    addr  = '0;
    logic          rd_s  = 1'b0;
    logic          wr_s  = 1'b0;
    logic [31:0]   wd    = '0;
    logic [31:0]   rdata;
    logic          irq;

    int n_chk  = 0;
    int n_pass = 0;

    always #10 clk = ~clk;

    risac_key_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) u_dut (
        .clock50       (clk),
        .reset         (rst),
        .sw_in         (sw),
        .avs_address   (addr),
        .avs_read      (rd_s),
        .avs_write     (wr_s),
        .avs_writedata (wd),
        .avs_readdata  (rdata),
        .irq           (irq)
    );

    // ---------------- reference model ----------------
    logic [W-1:0] m_d1, m_sync, m_p1, m_p2, m_db, m_ec, m_mask;
    logic [31:0]  m_rd;
    int           m_cyc;

    function automatic void model_reset();
        m_d1 = '0; m_sync = '0; m_p1 = '0; m_p2 = '0;
        m_db = '0; m_ec = '0; m_mask = '0; m_rd = '0; m_cyc = 0;
    endfunction

    function automatic logic [31:0] reg_val(input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            2'd0: v[W-1:0] = m_db;
            2'd1: v[W-1:0] = m_sync;
            2'd2: v[W-1:0] = m_mask;
            default: v[W-1:0] = m_ec;
        endcase
        return v;
    endfunction

    function automatic bit next_is_tick();
        return (m_cyc % D) == (D - 1);
    endfunction

    task automatic model_edge();
        logic [W-1:0] ndb, rise, clr;
        bit tick;
        if (rst) begin
            model_reset();
            return;
        end
        if (rd_s) m_rd = reg_val(addr);
        tick = next_is_tick();
        m_cyc++;
        ndb = m_db;
        if (tick) begin
            for (int i = 0; i < W; i++)
                if (m_sync[i] == m_p1[i] && m_p1[i] == m_p2[i]) ndb[i] = m_sync[i];
            m_p2 = m_p1;
            m_p1 = m_sync;
        end
        rise = ndb & ~m_db;
        clr  = (wr_s && addr == 2'd3) ? wd[W-1:0] : '0;
        m_ec = (m_ec & ~clr) | rise;
        if (wr_s && addr == 2'd2) m_mask = wd[W-1:0];
        m_db   = ndb;
        m_sync = m_d1;
        m_d1   = sw;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic compare();
        chk("readdata_model", rdata, m_rd);
        chk("irq_model", {31'b0, irq}, {31'b0, |(m_ec & m_mask)});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr = a; wd = d; wr_s = 1'b1;
        step();
        wr_s = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        addr = a; rd_s = 1'b1;
        step();
        rd_s = 1'b0;
        chk(name, rdata, exp);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        idle(2);
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] mask;
        logic [W-1:0] clr;
        logic [W-1:0] swv;
        logic [W-1:0] db;
        logic [W-1:0] ec;
        logic         irq;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        tbl[0] = '{10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 1'b0};
        tbl[1] = '{10'h000, 10'h000, 10'h001, 10'h001, 10'h001, 1'b0};
        tbl[2] = '{10'h001, 10'h000, 10'h001, 10'h001, 10'h001, 1'b1};
        tbl[3] = '{10'h001, 10'h3FE, 10'h001, 10'h001, 10'h001, 1'b1};
        tbl[4] = '{10'h001, 10'h001, 10'h001, 10'h001, 10'h000, 1'b0};
        tbl[5] = '{10'h0F0, 10'h000, 10'h0F1, 10'h0F1, 10'h0F0, 1'b1};
        tbl[6] = '{10'h0F0, 10'h0F0, 10'h000, 10'h000, 10'h000, 1'b0};
        tbl[7] = '{10'h3FF, 10'h000, 10'h2AA, 10'h2AA, 10'h2AA, 1'b1};

        // Reset state
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_readdata", rdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;

        for (int a = 0; a < 4; a++) bus_read(2'(a), 32'h0, "reset_read");

        // Table vectors
        for (int k = 0; k < 8; k++) begin
            bus_write(2'd2, {22'b0, tbl[k].mask});
            bus_write(2'd3, {22'b0, tbl[k].clr});
            sw = tbl[k].swv;
            idle(20);
            bus_read(2'd0, {22'b0, tbl[k].db}, "tbl_db");
            bus_read(2'd3, {22'b0, tbl[k].ec}, "tbl_ec");
            chk("tbl_irq", {31'b0, irq}, {31'b0, tbl[k].irq});
        end

        // Read and write to the same address in one cycle returns old value
        bus_write(2'd2, 32'h155);
        addr = 2'd2; rd_s = 1'b1; wr_s = 1'b1; wd = 32'h0AA;
        step();
        rd_s = 1'b0; wr_s = 1'b0;
        chk("rw_collision_old", rdata, 32'h155);
        bus_read(2'd2, 32'h0AA, "rw_collision_new");
        bus_write(2'd1, 32'h3FF);
        bus_write(2'd0, 32'h3FF);
        bus_read(2'd2, 32'h0AA, "ro_write_ignored");

        // Short pulse never reaches db
        apply_reset();
        sw = 10'h008;
        step(); step();
        addr = 2'd1; rd_s = 1'b1;
        step();
        rd_s = 1'b0; sw = '0;
        idle(40);
        bus_read(2'd0, 32'h0, "pulse_db");
        bus_read(3'd3, 32'h0, "pulse_ec");

        // W1C on the same edge db[0] rises: set wins
        apply_reset();
        sw = 10'h001;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (next_is_tick() && m_sync[0] && m_p1[0] && m_p2[0] && !m_db[0]) begin
                bus_write(2'd3, 32'h001);
                found = 1'b1;
            end else begin
                step();
            end
        end
        chk("w1c_race_reached", {31'b0, found}, 32'h1);
        bus_read(2'd3, 32'h001, "w1c_race_ec");

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) sw = sw ^ (W'(1) << $urandom_range(0, W - 1));
            rd_s = ($urandom_range(0, 3) == 0);
            wr_s = ($urandom_range(0, 3) == 0);
            addr = 2'($urandom_range(0, 3));
            wd   = $urandom;
            step();
        end
        rd_s = 1'b0; wr_s = 1'b0;

        // Asynchronous reset pulse between clock edges mid-debounce
        apply_reset();
        sw = 10'h3FF;
        idle(3);
        bus_read(2'd1, 32'h3FF, "pre_pulse_sync");
        idle(2);
        #2 rst = 1'b1;
        model_reset();
        #2;
        chk("async_rst_readdata", rdata, 32'h0);
        chk("async_rst_irq", {31'b0, irq}, 32'h0);
        #3 rst = 1'b0;
        idle(16);
        bus_read(2'd0, 32'h3FF, "post_rst_db");
        bus_read(2'd3, 32'h3FF, "post_rst_ec");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
